// File: rtl/emu_rst_ctrl_if.sv
// Signal bundle between the clock/VIO side (master) and the reset sequencer (slave).
// Every signal is a plain level or a single-cycle pulse; there is no valid/ready pair.
interface emu_rst_ctrl_if #(
  parameter int CNT_W = 8
);
  // locked/host_rst_req are asynchronous levels owned by the master; the sequencer
  // returns registered levels (emu_rst, state, rst_count) and the emu_rst_done pulse.
  logic             locked;
  logic             host_rst_req;
  logic             heartbeat;
  logic             emu_rst;
  logic             emu_rst_done;
  logic [1:0]       state;
  logic [CNT_W-1:0] rst_count;

  modport master (
    output locked, host_rst_req, heartbeat,
    input  emu_rst, emu_rst_done, state, rst_count
  );

  modport slave (
    input  locked, host_rst_req, heartbeat,
    output emu_rst, emu_rst_done, state, rst_count
  );
endinterface

// File: rtl/emu_rst_ctrl.sv
// Reset sequencer: synchronises clock lock and host reset request into a clean emu_rst.
// Define EMU_RST_WDOG_EN to add the heartbeat watchdog and the wdog_fired output.
module emu_rst_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_STABLE = 16,
  parameter int HOLD_CYCLES = 8,
  parameter int CNT_W       = 8,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic           clk,
  input  logic           rst_n,
  emu_rst_ctrl_if.slave  bus
`ifdef EMU_RST_WDOG_EN
  ,
  output logic           wdog_fired
`endif
);

  typedef enum logic [1:0] {
    LOCK_WAIT = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2,
    HOST      = 2'd3
  } state_e;

  localparam int LK_W = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;
  localparam int HD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [LK_W-1:0] LK_LAST = LK_W'(LOCK_STABLE - 1);
  localparam logic [HD_W-1:0] HD_LAST = HD_W'(HOLD_CYCLES - 1);

  logic [SYNC_STAGES-1:0] lk_sync_q, lk_sync_d;
  logic [SYNC_STAGES-1:0] rq_sync_q, rq_sync_d;
  logic                   rq_s_d_q, rq_s_d_d;
  state_e                 state_q, state_d;
  logic [LK_W-1:0]        lock_cnt_q, lock_cnt_d;
  logic [HD_W-1:0]        hold_cnt_q, hold_cnt_d;
  logic                   emu_rst_q, emu_rst_d;
  logic                   emu_rst_done_q, emu_rst_done_d;
  logic [CNT_W-1:0]       rst_count_q, rst_count_d;
  logic                   lk_s, rq_s, rq_rise;

`ifdef EMU_RST_WDOG_EN
  localparam int WD_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);

  logic [WD_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic            wdog_fired_q, wdog_fired_d;
  logic            wdog_hit;
`else
  logic unused_cfg;
  assign unused_cfg = bus.heartbeat ^ (WDOG_CYCLES == 0);
`endif

  always_comb begin
    lk_sync_d      = {lk_sync_q[SYNC_STAGES-2:0], bus.locked};
    rq_sync_d      = {rq_sync_q[SYNC_STAGES-2:0], bus.host_rst_req};
    lk_s           = lk_sync_q[SYNC_STAGES-1];
    rq_s           = rq_sync_q[SYNC_STAGES-1];
    rq_rise        = rq_s & ~rq_s_d_q;
    rq_s_d_d       = rq_s;
    state_d        = state_q;
    lock_cnt_d     = lock_cnt_q;
    hold_cnt_d     = hold_cnt_q;
`ifdef EMU_RST_WDOG_EN
    wdog_fired_d   = wdog_fired_q;
    wdog_hit       = !bus.heartbeat && (wdog_cnt_q == WD_LAST);
`endif

    // Lock loss outranks every other event, whatever the current state.
    if (!lk_s && (state_q != LOCK_WAIT)) begin
      state_d    = LOCK_WAIT;
      lock_cnt_d = '0;
    end else begin
      case (state_q)
        LOCK_WAIT: begin
          if (!lk_s) begin
            lock_cnt_d = '0;
          end else if (lock_cnt_q == LK_LAST) begin
            state_d    = HOLD;
            hold_cnt_d = '0;
          end else begin
            lock_cnt_d = lock_cnt_q + 1'b1;
          end
        end
        HOLD: begin
          if (rq_s) begin
            state_d = HOST;
          end else if (hold_cnt_q == HD_LAST) begin
            state_d = RUN;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        RUN: begin
          if (rq_rise) begin
            state_d = HOST;
          end
`ifdef EMU_RST_WDOG_EN
          else if (wdog_hit) begin
            state_d      = HOLD;
            hold_cnt_d   = '0;
            wdog_fired_d = 1'b1;
          end
`endif
        end
        HOST: begin
          if (!rq_s) begin
            state_d    = HOLD;
            hold_cnt_d = '0;
          end
        end
        default: state_d = LOCK_WAIT;
      endcase
    end

    // Outputs are registered copies of next-state decisions, so no input reaches an output combinationally.
    emu_rst_d      = (state_d != RUN);
    emu_rst_done_d = emu_rst_q && (state_d == RUN);
    rst_count_d    = rst_count_q;
    if ((state_q == HOLD) && (state_d == RUN) && (rst_count_q != {CNT_W{1'b1}})) begin
      rst_count_d = rst_count_q + 1'b1;
    end

`ifdef EMU_RST_WDOG_EN
    wdog_cnt_d = ((state_q == RUN) && (state_d == RUN) && !bus.heartbeat) ? wdog_cnt_q + 1'b1 : '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lk_sync_q      <= '0;
      rq_sync_q      <= '0;
      rq_s_d_q       <= 1'b0;
      state_q        <= LOCK_WAIT;
      lock_cnt_q     <= '0;
      hold_cnt_q     <= '0;
      emu_rst_q      <= 1'b1;
      emu_rst_done_q <= 1'b0;
      rst_count_q    <= '0;
`ifdef EMU_RST_WDOG_EN
      wdog_cnt_q     <= '0;
      wdog_fired_q   <= 1'b0;
`endif
    end else begin
      lk_sync_q      <= lk_sync_d;
      rq_sync_q      <= rq_sync_d;
      rq_s_d_q       <= rq_s_d_d;
      state_q        <= state_d;
      lock_cnt_q     <= lock_cnt_d;
      hold_cnt_q     <= hold_cnt_d;
      emu_rst_q      <= emu_rst_d;
      emu_rst_done_q <= emu_rst_done_d;
      rst_count_q    <= rst_count_d;
`ifdef EMU_RST_WDOG_EN
      wdog_cnt_q     <= wdog_cnt_d;
      wdog_fired_q   <= wdog_fired_d;
`endif
    end
  end

  assign bus.emu_rst      = emu_rst_q;
  assign bus.emu_rst_done = emu_rst_done_q;
  assign bus.state        = state_q;
  assign bus.rst_count    = rst_count_q;
`ifdef EMU_RST_WDOG_EN
  assign wdog_fired       = wdog_fired_q;
`endif

endmodule
